// File: rtl/rs_latch_driver.sv
// Self-checking initiator for a gated RS latch: plays an 8-step Clk/R/S
// sequence, samples the synchronised Q at the end of each step and reports results.
//
// state | meaning
// IDLE  | waiting for start, latch drives held low
// RUN   | stepping through the stimulus table, checking Q each step
// DONE  | run finished, results held until the next start
module rs_latch_driver #(
    parameter int unsigned HOLD_CYCLES = 50,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       start,
    input  logic       Q_in,
    output logic       Clk_out,
    output logic       R_out,
    output logic       S_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_mask,
    output logic [2:0] step
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]       LAST_STEP = 3'd7;

    // Stimulus per step, packed as {Clk, R, S}.
    function automatic logic [2:0] step_drive(input logic [2:0] idx);
        logic [2:0] drv;
        case (idx)
            3'd1:    drv = 3'b101;
            3'd3:    drv = 3'b110;
            3'd5:    drv = 3'b001;
            3'd6:    drv = 3'b101;
            3'd7:    drv = 3'b010;
            default: drv = 3'b000;
        endcase
        return drv;
    endfunction

    function automatic logic step_checked(input logic [2:0] idx);
        return (idx != 3'd0);
    endfunction

    function automatic logic step_expect(input logic [2:0] idx);
        logic q;
        case (idx)
            3'd1, 3'd2, 3'd6, 3'd7: q = 1'b1;
            default:                q = 1'b0;
        endcase
        return q;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       step_q, step_d;
    logic [2:0]       drive_q, drive_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       err_q, err_d;
    logic [7:0]       mask_q, mask_d;
    logic             q_meta_q;
    logic             q_s_q;
    logic             check_now;
    logic             miss;

    // Q_in comes from the latch and is asynchronous to CLOCK_50.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            q_meta_q <= 1'b0;
            q_s_q    <= 1'b0;
        end else begin
            q_meta_q <= Q_in;
            q_s_q    <= q_meta_q;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            step_q  <= 3'd0;
            drive_q <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            mask_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            drive_q <= drive_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    assign check_now = (state_q == S_RUN) && (cnt_q == HOLD_LAST);
    assign miss      = check_now && step_checked(step_q) && (q_s_q != step_expect(step_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        drive_d = drive_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                drive_d = 3'b000;
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    step_d  = 3'd0;
                    drive_d = step_drive(3'd0);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 4'd0;
                    mask_d  = 8'h00;
                end
            end
            S_RUN: begin
                if (check_now) begin
                    cnt_d = '0;
                    if (miss) begin
                        err_d  = err_q + 4'd1;
                        mask_d = mask_q | (8'b0000_0001 << step_q);
                    end
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 4'd0);
                        drive_d = 3'b000;
                    end else begin
                        step_d  = step_q + 3'd1;
                        drive_d = step_drive(step_q + 3'd1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                drive_d = 3'b000;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign Clk_out   = drive_q[2];
    assign R_out     = drive_q[1];
    assign S_out     = drive_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;
    assign step      = step_q;

endmodule
